serial_frame_argmax: RTL and testbench

Streaming arg-max/arg-min over framed serial input; successor to the single-stream serial argmax.
- Consumes one sample per accepted beat over a valid/ready handshake and tracks the running extreme value and its index within the frame.
- Presents {index, value, overflow} on a valid/ready output port after the beat marked last.
- Sits after per-element score producers (classifier outputs, correlator peaks) and feeds decision logic.

---
 rtl/serial_frame_argmax_if.sv | 27 ++
 rtl/serial_frame_argmax.sv | 130 +++++++++++++
 tb/tb_serial_frame_argmax.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_argmax_if.sv
// Valid/ready bundle for serial_frame_argmax: framed sample stream in, {index, value, overflow} result out.
// The master side drives samples and accepts results; the slave side is the arg-max block.
interface serial_frame_argmax_if #(
    parameter int WIDTH        = 8,
    parameter int ARGMAX_WIDTH = 3
);
    logic                    mode;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [ARGMAX_WIDTH-1:0] out_argmax;
    logic [WIDTH-1:0]        out_value;
    logic                    out_overflow;

    modport master (
        output mode, in_valid, in, in_last, out_ready,
        input  in_ready, out_valid, out_argmax, out_value, out_overflow
    );

    modport slave (
        input  mode, in_valid, in, in_last, out_ready,
        output in_ready, out_valid, out_argmax, out_value, out_overflow
    );
endinterface

// File: rtl/serial_frame_argmax.sv
// Streaming arg-max/arg-min over framed samples; result presented after the beat marked last.
// Optional SERIAL_FRAME_ARGMAX_TIE_LAST_EN: ties select the latest in-range index instead of the earliest.
module serial_frame_argmax #(
    parameter int WIDTH        = 8,
    parameter int ARGMAX_WIDTH = 3,
    parameter int SIGNED       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_frame_argmax_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [ARGMAX_WIDTH:0] IDX_ONE = (ARGMAX_WIDTH+1)'(1);

    state_t                  state;
    logic [WIDTH-1:0]        best_val_p0;
    logic [ARGMAX_WIDTH-1:0] best_idx_p0;
    logic [ARGMAX_WIDTH:0]   idx_p0;
    logic                    ovf_p0;
    logic                    mode_p0;

    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [ARGMAX_WIDTH-1:0] out_argmax_q;
    logic [WIDTH-1:0]        out_value_q;
    logic                    out_ovf_q;

    logic                    accept;
    logic                    win;
    logic [WIDTH-1:0]        nxt_val;
    logic [ARGMAX_WIDTH-1:0] nxt_idx;
    logic                    nxt_ovf;

    // One guard bit lets a single signed compare serve both signed and unsigned samples.
    function automatic logic beats(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic m);
        logic signed [WIDTH:0] sa;
        logic signed [WIDTH:0] sb;
        sa = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
        sb = (SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b};
`ifdef SERIAL_FRAME_ARGMAX_TIE_LAST_EN
        return m ? (sa <= sb) : (sa >= sb);
`else
        return m ? (sa < sb) : (sa > sb);
`endif
    endfunction

    always_comb begin
        accept  = bus.in_valid & in_ready_q;
        // idx_p0 MSB set means the frame has run past the last representable index.
        win     = ~idx_p0[ARGMAX_WIDTH] & beats(bus.in, best_val_p0, mode_p0);
        nxt_val = win ? bus.in : best_val_p0;
        nxt_idx = win ? idx_p0[ARGMAX_WIDTH-1:0] : best_idx_p0;
        nxt_ovf = ovf_p0 | idx_p0[ARGMAX_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_argmax_q <= '0;
            out_value_q  <= '0;
            out_ovf_q    <= 1'b0;
            best_val_p0  <= '0;
            best_idx_p0  <= '0;
            idx_p0       <= '0;
            ovf_p0       <= 1'b0;
            mode_p0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        best_val_p0 <= bus.in;
                        best_idx_p0 <= '0;
                        mode_p0     <= bus.mode;
                        idx_p0      <= IDX_ONE;
                        ovf_p0      <= 1'b0;
                        if (bus.in_last) begin
                            out_value_q  <= bus.in;
                            out_argmax_q <= '0;
                            out_ovf_q    <= 1'b0;
                            out_valid_q  <= 1'b1;
                            in_ready_q   <= 1'b0;
                            state        <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        best_val_p0 <= nxt_val;
                        best_idx_p0 <= nxt_idx;
                        ovf_p0      <= nxt_ovf;
                        if (!idx_p0[ARGMAX_WIDTH]) begin
                            idx_p0 <= idx_p0 + IDX_ONE;
                        end
                        if (bus.in_last) begin
                            out_value_q  <= nxt_val;
                            out_argmax_q <= nxt_idx;
                            out_ovf_q    <= nxt_ovf;
                            out_valid_q  <= 1'b1;
                            in_ready_q   <= 1'b0;
                            state        <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        idx_p0      <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_argmax   = out_argmax_q;
    assign bus.out_value    = out_value_q;
    assign bus.out_overflow = out_ovf_q;
endmodule

// File: tb/tb_serial_frame_argmax.sv
// Directed table-driven bench for serial_frame_argmax: signed and unsigned instances share one stimulus stream.
// Expected values follow the SERIAL_FRAME_ARGMAX_TIE_LAST_EN build choice where ties matter.
module tb_serial_frame_argmax;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int NV = 10;

`ifdef SERIAL_FRAME_ARGMAX_TIE_LAST_EN
    localparam bit TIE = 1'b1;
`else
    localparam bit TIE = 1'b0;
`endif

    typedef struct packed {
        logic              m;
        int                len;
        logic [0:11][7:0]  s;
        logic [AW-1:0]     idx_s;
        logic [W-1:0]      val_s;
        logic [AW-1:0]     idx_u;
        logic [W-1:0]      val_u;
        logic              ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic mode, in_valid, in_last, out_ready;
    logic [W-1:0] din;
    logic [0:11][7:0] cur_s;
    int n_checks = 0;
    int n_err    = 0;
    vec_t vec [NV];

    serial_frame_argmax_if #(.WIDTH(W), .ARGMAX_WIDTH(AW)) ifs ();
    serial_frame_argmax_if #(.WIDTH(W), .ARGMAX_WIDTH(AW)) ifu ();

    assign ifs.mode = mode;  assign ifs.in_valid = in_valid;  assign ifs.in = din;
    assign ifs.in_last = in_last;  assign ifs.out_ready = out_ready;
    assign ifu.mode = mode;  assign ifu.in_valid = in_valid;  assign ifu.in = din;
    assign ifu.in_last = in_last;  assign ifu.out_ready = out_ready;

    serial_frame_argmax #(.WIDTH(W), .ARGMAX_WIDTH(AW), .SIGNED(1)) u_dut_s (.clk(clk), .rst(rst), .bus(ifs));
    serial_frame_argmax #(.WIDTH(W), .ARGMAX_WIDTH(AW), .SIGNED(0)) u_dut_u (.clk(clk), .rst(rst), .bus(ifu));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_err);
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic m, input int len, input logic [0:11][7:0] s,
                                input logic [AW-1:0] is, input logic [W-1:0] vs,
                                input logic [AW-1:0] iu, input logic [W-1:0] vu, input logic ovf);
        vec_t v;
        v.m = m; v.len = len; v.s = s; v.idx_s = is; v.val_s = vs;
        v.idx_u = iu; v.val_u = vu; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives a frame from cur_s; mode flips after the first beat and must be ignored.
    task automatic send_frame(input logic m, input int len);
        for (int i = 0; i < len; i++) begin
            int waited = 0;
            in_valid = 1'b1;
            din      = cur_s[i];
            in_last  = (i == len - 1);
            mode     = (i == 0) ? m : ~m;
            while (!ifs.in_ready && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!ifs.in_ready) begin
                check("in_ready_timeout", ifs.in_ready, 1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [AW-1:0] is, input logic [W-1:0] vs,
                                input logic [AW-1:0] iu, input logic [W-1:0] vu, input logic ovf);
        check({tag, ".out_valid_s"}, ifs.out_valid, 1);
        check({tag, ".out_valid_u"}, ifu.out_valid, 1);
        check({tag, ".argmax_s"}, ifs.out_argmax, is);
        check({tag, ".value_s"}, ifs.out_value, vs);
        check({tag, ".overflow_s"}, ifs.out_overflow, ovf);
        check({tag, ".argmax_u"}, ifu.out_argmax, iu);
        check({tag, ".value_u"}, ifu.out_value, vu);
        check({tag, ".overflow_u"}, ifu.out_overflow, ovf);
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, ifs.out_valid, 0);
        check({tag, ".in_ready_back"}, ifs.in_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".in_ready"}, ifs.in_ready, 1);
        check({tag, ".out_valid"}, ifs.out_valid, 0);
        check({tag, ".argmax"}, ifs.out_argmax, 0);
        check({tag, ".value"}, ifs.out_value, 0);
        check({tag, ".overflow"}, ifs.out_overflow, 0);
        check({tag, ".u_out_valid"}, ifu.out_valid, 0);
        check({tag, ".u_value"}, ifu.out_value, 0);
    endtask

    initial begin
        vec[0] = mk(1'b0, 6, {8'h03, 8'hFB, 8'h07, 8'h02, 8'h07, 8'h01, {6{8'h00}}},
                    TIE ? 3'd4 : 3'd2, 8'h07, 3'd1, 8'hFB, 1'b0);
        vec[1] = mk(1'b1, 6, {8'h03, 8'hFB, 8'h07, 8'h02, 8'h07, 8'h01, {6{8'h00}}},
                    3'd1, 8'hFB, 3'd5, 8'h01, 1'b0);
        vec[2] = mk(1'b0, 10, {{4{8'h00}}, 8'h32, {4{8'h00}}, 8'h7F, {2{8'h00}}},
                    3'd4, 8'h32, 3'd4, 8'h32, 1'b1);
        vec[3] = mk(1'b1, 10, {{4{8'h00}}, 8'h32, {4{8'h00}}, 8'h7F, {2{8'h00}}},
                    TIE ? 3'd7 : 3'd0, 8'h00, TIE ? 3'd7 : 3'd0, 8'h00, 1'b1);
        vec[4] = mk(1'b0, 1, {8'h09, {11{8'h00}}}, 3'd0, 8'h09, 3'd0, 8'h09, 1'b0);
        vec[5] = mk(1'b0, 8, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, {4{8'h00}}},
                    3'd7, 8'h08, 3'd7, 8'h08, 1'b0);
        vec[6] = mk(1'b1, 4, {8'h0A, 8'h80, 8'h7F, 8'hFF, {8{8'h00}}}, 3'd1, 8'h80, 3'd0, 8'h0A, 1'b0);
        vec[7] = mk(1'b0, 4, {8'h0A, 8'h80, 8'h7F, 8'hFF, {8{8'h00}}}, 3'd2, 8'h7F, 3'd3, 8'hFF, 1'b0);
        vec[8] = mk(1'b0, 3, {{3{8'h05}}, {9{8'h00}}},
                    TIE ? 3'd2 : 3'd0, 8'h05, TIE ? 3'd2 : 3'd0, 8'h05, 1'b0);
        vec[9] = mk(1'b0, 9, {{8{8'h00}}, 8'h64, {3{8'h00}}},
                    TIE ? 3'd7 : 3'd0, 8'h00, TIE ? 3'd7 : 3'd0, 8'h00, 1'b1);

        rst = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; din = '0;
        cur_s = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset_init");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            cur_s = vec[k].s;
            send_frame(vec[k].m, vec[k].len);
            check_result($sformatf("vec%0d", k), vec[k].idx_s, vec[k].val_s,
                         vec[k].idx_u, vec[k].val_u, vec[k].ovf);
            handoff($sformatf("vec%0d", k));
        end

        // Stall: result held with a sample waiting upstream; nothing may be consumed.
        cur_s = vec[0].s;
        send_frame(1'b0, 6);
        check_result("stall", vec[0].idx_s, 8'h07, 3'd1, 8'hFB, 1'b0);
        in_valid = 1'b1; din = 8'h20; in_last = 1'b1; mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d.in_ready", c), ifs.in_ready, 0);
            check($sformatf("stall%0d.out_valid", c), ifs.out_valid, 1);
            check($sformatf("stall%0d.value", c), ifs.out_value, 8'h07);
            check($sformatf("stall%0d.argmax", c), ifs.out_argmax, vec[0].idx_s);
        end
        handoff("stall");
        cur_s = {8'h20, {11{8'h00}}};
        send_frame(1'b0, 1);
        check_result("after_stall", 3'd0, 8'h20, 3'd0, 8'h20, 1'b0);
        handoff("after_stall");

        // Reset mid-frame after three beats.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_last = 1'b0; din = 8'(50 + 10 * i); mode = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("reset_mid");
        rst = 1'b1;
        cur_s = {8'h09, {11{8'h00}}};
        send_frame(1'b0, 1);
        check_result("post_reset_mid", 3'd0, 8'h09, 3'd0, 8'h09, 1'b0);
        handoff("post_reset_mid");

        // Reset while a result is held.
        cur_s = {8'h14, 8'h1E, {10{8'h00}}};
        send_frame(1'b0, 2);
        check_result("pre_reset_hold", 3'd1, 8'h1E, 3'd1, 8'h1E, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("reset_hold");
        rst = 1'b1;
        cur_s = {8'h09, {11{8'h00}}};
        send_frame(1'b0, 1);
        check_result("post_reset_hold", 3'd0, 8'h09, 3'd0, 8'h09, 1'b0);
        handoff("post_reset_hold");

        // Back-to-back single-beat frames, downstream always ready, random input gaps.
        out_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            logic [7:0] v;
            int gap;
            gap = $urandom_range(0, 3);
            v   = 8'($urandom);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            cur_s = {v, {11{8'h00}}};
            send_frame(1'($urandom), 1);
            check_result($sformatf("single%0d", f), 3'd0, v, 3'd0, v, 1'b0);
            @(posedge clk); #1;
            check($sformatf("single%0d.valid_drop", f), ifs.out_valid, 0);
            check($sformatf("single%0d.in_ready", f), ifs.in_ready, 1);
        end
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
